// File: rtl/ucie_sbinit_pkg.sv
// ucie_sbinit_pkg: sideband message encodings and SBINIT state enum shared by the RX and TX SBINIT blocks
package ucie_sbinit_pkg;
  localparam int OUT_OF_RESET = 1;
  localparam int DONE_REQ = 2;
  localparam int DONE_RESP = 3;
  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    WAIT_DONE_REQ  = 3'd1,
    SEND_DONE_RESP = 3'd2,
    SBINIT_END     = 3'd3,
    TIMEOUT        = 3'd4
  } sbinit_state_t;
endpackage

// File: rtl/sbinit_timeout_cnt.sv
// sbinit_timeout_cnt: saturating residency counter (clk, rst, clr, en in; tc high once count reaches LIMIT-1)
module sbinit_timeout_cnt #(
  parameter int LIMIT = 800000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int W = $clog2(LIMIT) + 1;
  logic [W-1:0] cnt;
  assign tc = cnt >= W'(LIMIT - 1);
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en && !tc) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/rx_sbinit_resp.sv
// rx_sbinit_resp: SBINIT responder; waits for done_req, sends done_resp under i_SB_Busy backpressure, flags end/timeout (i_clk, i_rst, i_SBINIT_en, i_rx_valid, i_decoded_SB_msg, i_SB_Busy in; o_valid_rx, o_encoded_SB_msg_rx, o_SBINIT_end_rx, o_timeout registered out)
module rx_sbinit_resp
  import ucie_sbinit_pkg::*;
#(
  parameter int SB_MSG_WIDTH   = 4,
  parameter int TIMEOUT_CYCLES = 800000
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_SBINIT_en,
  input  logic                    i_rx_valid,
  input  logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg,
  input  logic                    i_SB_Busy,
  output logic                    o_valid_rx,
  output logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg_rx,
  output logic                    o_SBINIT_end_rx,
  output logic                    o_timeout
);
  sbinit_state_t state, nxt;
  logic tc;
  logic done_req;
  assign done_req = i_rx_valid && (i_decoded_SB_msg == SB_MSG_WIDTH'(DONE_REQ));
  sbinit_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_cnt (
    .clk(i_clk),
    .rst(i_rst),
    .clr(state == IDLE),
    .en (state == WAIT_DONE_REQ || state == SEND_DONE_RESP),
    .tc (tc)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE:           nxt = WAIT_DONE_REQ;
      WAIT_DONE_REQ:  nxt = done_req ? SEND_DONE_RESP : tc ? TIMEOUT : WAIT_DONE_REQ;
      SEND_DONE_RESP: nxt = !i_SB_Busy ? SBINIT_END : tc ? TIMEOUT : SEND_DONE_RESP;
      SBINIT_END:     nxt = SBINIT_END;
      TIMEOUT:        nxt = TIMEOUT;
      default:        nxt = IDLE;
    endcase
    if (!i_SBINIT_en) nxt = IDLE;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state               <= IDLE;
      o_valid_rx          <= 1'b0;
      o_encoded_SB_msg_rx <= '0;
      o_SBINIT_end_rx     <= 1'b0;
      o_timeout           <= 1'b0;
    end else begin
      state               <= nxt;
      o_valid_rx          <= nxt == SEND_DONE_RESP;
      o_encoded_SB_msg_rx <= nxt == SEND_DONE_RESP ? SB_MSG_WIDTH'(DONE_RESP) : '0;
      o_SBINIT_end_rx     <= nxt == SBINIT_END;
      o_timeout           <= nxt == TIMEOUT;
    end
  end
endmodule
